// File: rtl/match_pkg.sv
// ============================================================================
// Module      : match_pkg
// Description : Shared state encoding and default scoring limits for match_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package match_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SERVE = 3'd1;
    localparam logic [2:0] c_ST_RALLY = 3'd2;
    localparam logic [2:0] c_ST_POINT = 3'd3;
    localparam logic [2:0] c_ST_OVER  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_SERVE = c_ST_SERVE,
        ST_RALLY = c_ST_RALLY,
        ST_POINT = c_ST_POINT,
        ST_OVER  = c_ST_OVER
    } state_t;

    localparam int c_DEF_PTS_TO_WIN  = 5;
    localparam int c_DEF_SETS_TO_WIN = 2;

endpackage

`default_nettype wire

// File: rtl/edge_det.sv
// ============================================================================
// Module      : edge_det
// Description : Rising-edge detector with a two-flop level history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pedge
);

    logic r_cur;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_cur  <= i_level;
            r_prev <= r_cur;
        end
    end

    assign o_pedge = r_cur & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/match_ctrl.sv
// ============================================================================
// Module      : match_ctrl
// Description : Serve/rally/point sequencer with game and match scoring.
//               Define DEUCE_EN to require a two-point lead to win a game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_ctrl
    import match_pkg::*;
#(
    parameter int PTS_TO_WIN  = c_DEF_PTS_TO_WIN,
    parameter int SETS_TO_WIN = c_DEF_SETS_TO_WIN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kick,
    input  logic       win1,
    input  logic       win2,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic [2:0] tsc1,
    output logic [2:0] tsc2,
    output logic [2:0] st,
    output logic       srv,
    output logic       toIDLE,
    output logic       match_over
);

    localparam logic [2:0] c_PTS    = 3'(PTS_TO_WIN);
    localparam logic [2:0] c_PTS_M1 = 3'(PTS_TO_WIN - 1);
    localparam logic [2:0] c_SETS   = 3'(SETS_TO_WIN);

    state_t     r_state;
    logic [2:0] r_sc1, r_sc2, r_tsc1, r_tsc2;
    logic       r_srv;

    state_t     w_nxt_state;
    logic [2:0] w_nxt_sc1, w_nxt_sc2, w_nxt_tsc1, w_nxt_tsc2;
    logic       w_nxt_srv;
    logic       w_pe1, w_pe2;
    logic [2:0] w_win_pts;
    logic [2:0] w_tsc_won;
    logic       w_game_won;

    edge_det u_edge1 (.clk(clk), .rst(reset), .i_level(win1), .o_pedge(w_pe1));
    edge_det u_edge2 (.clk(clk), .rst(reset), .i_level(win2), .o_pedge(w_pe2));

    // In POINT the server is always the player who just took the point.
    assign w_win_pts = r_srv ? r_sc2 : r_sc1;
    assign w_tsc_won = (r_srv ? r_tsc2 : r_tsc1) + 3'd1;

`ifdef DEUCE_EN
    logic [2:0] w_lose_pts;
    logic       w_deuce;
    assign w_lose_pts = r_srv ? r_sc1 : r_sc2;
    assign w_game_won = (w_win_pts >= c_PTS) &&
                        ({1'b0, w_win_pts} >= ({1'b0, w_lose_pts} + 4'd2));
    assign w_deuce    = (r_sc1 == c_PTS) && (r_sc2 == c_PTS);
`else
    assign w_game_won = (w_win_pts == c_PTS);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sc1   <= 3'd0;
            r_sc2   <= 3'd0;
            r_tsc1  <= 3'd0;
            r_tsc2  <= 3'd0;
            r_srv   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_sc1   <= w_nxt_sc1;
            r_sc2   <= w_nxt_sc2;
            r_tsc1  <= w_nxt_tsc1;
            r_tsc2  <= w_nxt_tsc2;
            r_srv   <= w_nxt_srv;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sc1   = r_sc1;
        w_nxt_sc2   = r_sc2;
        w_nxt_tsc1  = r_tsc1;
        w_nxt_tsc2  = r_tsc2;
        w_nxt_srv   = r_srv;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (kick) begin
                    w_nxt_state = ST_SERVE;
                    w_nxt_sc1   = 3'd0;
                    w_nxt_sc2   = 3'd0;
                    w_nxt_tsc1  = 3'd0;
                    w_nxt_tsc2  = 3'd0;
                    w_nxt_srv   = 1'b0;
                end
            end
            ST_SERVE: begin
                if (kick) w_nxt_state = ST_RALLY;
            end
            ST_RALLY: begin
                if (w_pe1 && w_pe2) begin
                    w_nxt_state = ST_SERVE;
                end else if (w_pe1) begin
                    w_nxt_sc1   = r_sc1 + 3'd1;
                    w_nxt_srv   = 1'b0;
                    w_nxt_state = ST_POINT;
                end else if (w_pe2) begin
                    w_nxt_sc2   = r_sc2 + 3'd1;
                    w_nxt_srv   = 1'b1;
                    w_nxt_state = ST_POINT;
                end
            end
            ST_POINT: begin
                w_nxt_state = ST_SERVE;
                if (w_game_won) begin
                    w_nxt_sc1 = 3'd0;
                    w_nxt_sc2 = 3'd0;
                    if (r_srv) w_nxt_tsc2 = w_tsc_won;
                    else       w_nxt_tsc1 = w_tsc_won;
                    if (w_tsc_won == c_SETS) w_nxt_state = ST_OVER;
                end
`ifdef DEUCE_EN
                else if (w_deuce) begin
                    w_nxt_sc1 = c_PTS_M1;
                    w_nxt_sc2 = c_PTS_M1;
                end
`endif
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        st         = r_state;
        toIDLE     = (r_state == ST_POINT);
        match_over = (r_state == ST_OVER);
    end

    assign sc1  = r_sc1;
    assign sc2  = r_sc2;
    assign tsc1 = r_tsc1;
    assign tsc2 = r_tsc2;
    assign srv  = r_srv;

endmodule

`default_nettype wire

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 SHALL have parameter PTS_TO_WIN, default 5, points needed to win a game (legal range 2..6).
REQ-002 SHALL have parameter SETS_TO_WIN, default 2, games needed to win the match (legal range 1..7).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port kick, input, 1 bit: serve/start request, level sampled each cycle.
REQ-006 SHALL have ports win1 and win2, input, 1 bit each: point-won levels from the ball datapath for player 1 and player 2.
REQ-007 SHALL have ports sc1 and sc2, output, 3 bits each: current game points for each player.
REQ-008 SHALL have ports tsc1 and tsc2, output, 3 bits each: games won by each player.
REQ-009 SHALL have port st, output, 3 bits: state code, with IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4.
REQ-010 SHALL have port srv, output, 1 bit: current server, 0 = player 1, 1 = player 2.
REQ-011 SHALL have port toIDLE, output, 1 bit: one-cycle pulse telling the ball datapath to park the ball.
REQ-012 SHALL have port match_over, output, 1 bit: high while st is OVER.

Function
REQ-013 SHALL detect rising edges of win1 and win2 with a 2-flop history (pedge = cur & !prev); a win first sampled high at edge n yields pedge during cycle n+1.
REQ-014 In IDLE, SHALL move to SERVE on kick, with srv=0 and all scores 0.
REQ-015 In SERVE, SHALL move to RALLY on kick and SHALL ignore win edges.
REQ-016 In RALLY, a lone pedge1 (or pedge2) SHALL add 1 to sc1 (or sc2), set srv to the point winner, and move to POINT, all on the same edge.
REQ-017 In RALLY, simultaneous pedge1 and pedge2 SHALL score nothing and return to SERVE with srv unchanged (let).
REQ-018 In RALLY, kick SHALL be ignored.
REQ-019 POINT SHALL last exactly one cycle, and toIDLE SHALL be 1 in that cycle only.
REQ-020 On leaving POINT, if the game is won: clear sc1/sc2 and add 1 to the winner's tsc; go to OVER if that tsc reaches SETS_TO_WIN, otherwise go to SERVE.
REQ-021 On leaving POINT, if the game is not won, SHALL go to SERVE.
REQ-022 In OVER, scores SHALL hold; kick SHALL clear all scores, set srv=0, and go to SERVE.
REQ-023 Win edges outside RALLY SHALL be discarded and never queued.
REQ-024 Score arithmetic SHALL be unsigned 3-bit and can never exceed 7 given the legal parameter ranges; no wrap path is reachable.

Reset
REQ-025 reset SHALL override all other inputs in the cycle it is sampled.
REQ-026 On reset: st=IDLE, sc1=sc2=tsc1=tsc2=0, srv=0, toIDLE=0, match_over=0, edge-history flops=0.
REQ-027 Reset mid-rally or in POINT SHALL discard any pending point.
REQ-028 A win held high across reset releases SHALL produce one pedge, which is ignored because st is IDLE.

Configuration
REQ-029 With DEUCE_EN defined, a game SHALL be won only when the winner has at least PTS_TO_WIN points and leads by at least 2.
REQ-030 With DEUCE_EN defined, when both players reach PTS_TO_WIN, both SHALL be set to PTS_TO_WIN-1 on the POINT exit edge.
REQ-031 Without DEUCE_EN, a game SHALL be won when the winner's points equal PTS_TO_WIN.

Structure
REQ-032 Package match_pkg SHALL hold the state enum, the state codes, and the default PTS/SETS constants.
REQ-033 The edge detector SHALL be a sub-module edge_det, instantiated twice.
REQ-034 The FSM and scoring logic SHALL live in match_ctrl.

Verification (PTS_TO_WIN=3, SETS_TO_WIN=2)
REQ-035 Reset, kick, kick, then win1 pulse -> st 0→1→2, sc1=1 two edges after win1, toIDLE high 1 cycle, st=1, srv=0.
REQ-036 win1 and win2 rising on the same edge during RALLY -> sc1=sc2=0, st=SERVE, srv unchanged, no toIDLE.
REQ-037 Player 2 wins 3 rallies -> sc2 clears to 0, tsc2=1, st=SERVE, srv=1.
REQ-038 Player 1 wins 6 straight rallies -> tsc1=2, st=OVER, match_over=1; a later kick -> all scores 0, st=SERVE.
REQ-039 DEUCE_EN build, rallies alternating to 2-2, then P1, P2 -> sc1=sc2=2 after POINT; then P1, P1 -> tsc1=1.
REQ-040 Assert reset during RALLY with win1 rising the same cycle -> st=IDLE, all scores 0, no toIDLE pulse.
